axi_mp_bridge: RTL and testbench

AXI_MP_BRIDGE -- requirements
Module: axi_mp_bridge

---
 rtl/axi_mp_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_mp_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mp_bridge.sv
// Arbitrates NUM_MST SRAM-like masters onto one AXI3 master port with one outstanding transaction.
// Define BRIDGE_RR_ARB_EN for round-robin arbitration; default is fixed priority (highest index wins).
module axi_mp_bridge #(
    parameter int NUM_MST   = 2,
    parameter int MAX_BEATS = 16
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic [NUM_MST-1:0]    m_req,
    input  logic [NUM_MST-1:0]    m_wr,
    input  logic [2*NUM_MST-1:0]  m_size,
    input  logic [8*NUM_MST-1:0]  m_len,
    input  logic [32*NUM_MST-1:0] m_addr,
    output logic [NUM_MST-1:0]    m_addr_ok,
    input  logic [32*NUM_MST-1:0] m_wdata,
    input  logic [4*NUM_MST-1:0]  m_wstrb,
    input  logic [NUM_MST-1:0]    m_wvalid,
    output logic [NUM_MST-1:0]    m_wready,
    output logic [NUM_MST-1:0]    m_ret_valid,
    output logic [NUM_MST-1:0]    m_wr_done,
    output logic [31:0]           m_ret_data,
    output logic                  m_ret_last,
    output logic                  m_resp_err,
    output logic [3:0]            arid,
    output logic [31:0]           araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [3:0]            awid,
    output logic [31:0]           awaddr,
    output logic [3:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [3:0]            wid,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;

    logic [2:0]    state;
    logic [GW-1:0] gnt_q;
    logic [GW-1:0] pick;
    logic [1:0]    size_q;
    logic [3:0]    len_q;
    logic [31:0]   addr_q;
    logic [CW-1:0] cnt;
    logic          sel_wr;
    logic [1:0]    sel_size;
    logic [3:0]    sel_len;
    logic [31:0]   sel_addr;
    logic          g_wvalid;
    logic [31:0]   g_wdata;
    logic [3:0]    g_wstrb;
    logic          unused_ok;

`ifdef BRIDGE_RR_ARB_EN
    logic [GW-1:0]          ptr;
    logic [2*NUM_MST-1:0]   rot;
    logic                   found;

    // Rotate the request vector so the search begins at the pointer.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        rot   = {m_req, m_req} >> ptr;
        for (int k = 0; k < NUM_MST; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pick  = GW'((int'(ptr) + k) % NUM_MST);
            end
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (m_req[k]) pick = GW'(k);
        end
    end
`endif

    always_comb begin
        sel_wr   = 1'b0;
        sel_size = '0;
        sel_len  = '0;
        sel_addr = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (pick == GW'(k)) begin
                sel_wr   = m_wr[k];
                sel_size = m_size[2*k +: 2];
                sel_len  = m_len[8*k +: 4];
                sel_addr = m_addr[32*k +: 32];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state  <= S_IDLE;
            gnt_q  <= '0;
            size_q <= '0;
            len_q  <= '0;
            addr_q <= '0;
            cnt    <= '0;
`ifdef BRIDGE_RR_ARB_EN
            ptr    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (|m_req) begin
                    gnt_q  <= pick;
                    size_q <= sel_size;
                    len_q  <= sel_len;
                    addr_q <= sel_addr;
                    cnt    <= '0;
                    state  <= sel_wr ? S_AW : S_AR;
`ifdef BRIDGE_RR_ARB_EN
                    ptr    <= (pick == GW'(NUM_MST - 1)) ? '0 : pick + 1'b1;
`endif
                end
                S_AR: if (arready) state <= S_R;
                S_R:  if (rvalid && rlast) state <= S_IDLE;
                S_AW: if (awready) state <= S_W;
                S_W:  if (wvalid && wready) begin
                    cnt <= cnt + 1'b1;
                    if (wlast) state <= S_B;
                end
                S_B:  if (bvalid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-master outputs are steered to the granted master only; everyone else sees zero.
    always_comb begin
        m_addr_ok   = '0;
        m_wready    = '0;
        m_ret_valid = '0;
        m_wr_done   = '0;
        g_wvalid    = 1'b0;
        g_wdata     = '0;
        g_wstrb     = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (gnt_q == GW'(k)) begin
                m_addr_ok[k]   = (arvalid && arready) || (awvalid && awready);
                m_wready[k]    = (state == S_W) && wready;
                m_ret_valid[k] = rready && rvalid;
                m_wr_done[k]   = bready && bvalid;
                g_wvalid       = m_wvalid[k];
                g_wdata        = m_wdata[32*k +: 32];
                g_wstrb        = m_wstrb[4*k +: 4];
            end
        end
    end

    assign arvalid = (state == S_AR);
    assign awvalid = (state == S_AW);
    assign rready  = (state == S_R);
    assign bready  = (state == S_B);

    assign arid    = 4'(gnt_q);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = 4'(gnt_q);
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    // The beat counter, not the master, decides the last write beat.
    assign wid     = 4'(gnt_q);
    assign wvalid  = (state == S_W) && g_wvalid;
    assign wdata   = g_wdata;
    assign wstrb   = g_wstrb;
    assign wlast   = (state == S_W) && (cnt == len_q[CW-1:0]);

    assign m_ret_data = rready ? rdata : 32'h0;
    assign m_ret_last = rready && rlast;
    assign m_resp_err = (rready && rvalid && rresp[1]) || (bready && bvalid && bresp[1]);

    assign unused_ok = ^{rid, bid, rresp[0], bresp[0], m_len};
endmodule

// File: tb/tb_axi_mp_bridge.sv
// Randomized bench for axi_mp_bridge: models masters and an AXI slave, predicts grants and beats.
module tb_axi_mp_bridge;
    localparam int NM = 2;

    logic            aclk = 1'b0;
    logic            reset;
    logic [NM-1:0]   m_req, m_wr, m_addr_ok, m_wvalid, m_wready, m_ret_valid, m_wr_done;
    logic [2*NM-1:0] m_size;
    logic [8*NM-1:0] m_len;
    logic [32*NM-1:0] m_addr, m_wdata;
    logic [4*NM-1:0] m_wstrb;
    logic [31:0]     m_ret_data;
    logic            m_ret_last, m_resp_err;
    logic [3:0]      arid, arlen, arcache, awid, awlen, awcache, rid, wid, wstrb, bid;
    logic [31:0]     araddr, awaddr, rdata, wdata;
    logic [2:0]      arsize, arprot, awsize, awprot;
    logic [1:0]      arburst, arlock, awburst, awlock, rresp, bresp;
    logic            arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic            wlast, wvalid, wready, bvalid, bready;

    axi_mp_bridge #(.NUM_MST(NM), .MAX_BEATS(16)) dut (
        .aclk(aclk), .reset(reset),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_len(m_len), .m_addr(m_addr),
        .m_addr_ok(m_addr_ok), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_ret_valid(m_ret_valid), .m_wr_done(m_wr_done),
        .m_ret_data(m_ret_data), .m_ret_last(m_ret_last), .m_resp_err(m_resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int rr_ptr = 0;
    logic [NM-1:0] pend;
    logic       req_wr[NM];
    logic [1:0] req_size[NM];
    logic [7:0] req_len[NM];
    logic [31:0] req_addr[NM];
    int ar_delay_force = -1;
    int abort_at = -1;
    int glitch_m = -1;
    int rresp_force = -1;
    int bresp_force = -1;
    bit wtoggle = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int k, input logic wr, input logic [1:0] sz,
                           input logic [7:0] len, input logic [31:0] addr);
        req_wr[k] = wr; req_size[k] = sz; req_len[k] = len; req_addr[k] = addr;
        m_wr[k] = wr;
        m_size[2*k +: 2] = sz;
        m_len[8*k +: 8] = len;
        m_addr[32*k +: 32] = addr;
        m_req[k] = 1'b1;
        pend[k] = 1'b1;
    endtask

    // Which pending master the arbitration rule selects.
    function automatic int exp_grant(input logic [NM-1:0] p, input int ptr);
`ifdef BRIDGE_RR_ARB_EN
        for (int k = 0; k < NM; k++) if (p[(ptr + k) % NM]) return (ptr + k) % NM;
`else
        for (int k = NM - 1; k >= 0; k--) if (p[k]) return k;
`endif
        return 0;
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a, input int b);
        return a ^ (32'h9E37_79B9 * 32'(b + 1));
    endfunction

    function automatic logic [31:0] wd_val(input int g, input int b);
        return {16'hC0DE, 8'(g), 8'(b)};
    endfunction

    function automatic logic [3:0] ws_val(input int b);
        return 4'((b * 5) + 3);
    endfunction

    task automatic serve();
        int g, waitc, d, gap, b, cyc, len;
        bit is_wr, hs, wv, wrdy;
        logic [1:0] resp;
        g = exp_grant(pend, rr_ptr);
        is_wr = req_wr[g];
        len = int'(req_len[g]);
        tick();
        waitc = 0;
        while (!arvalid && !awvalid && waitc < 20) begin tick(); waitc++; end
        chk("grant_lat", waitc, 0);
        chk("chan_sel", {awvalid, arvalid}, is_wr ? 2'b10 : 2'b01);
        if (!arvalid && !awvalid) begin m_req = '0; pend = '0; return; end
        d = (ar_delay_force >= 0) ? ar_delay_force : $urandom_range(0, 3);
        for (int i = 0; i <= d; i++) begin
            if (i == d) begin arready = !is_wr; awready = is_wr; end
            settle();
            chk("addr_ok", m_addr_ok, (i == d) ? (1 << g) : 0);
            if (i < d) begin
                chk("valid_hold", {awvalid, arvalid}, is_wr ? 2'b10 : 2'b01);
                tick();
            end else if (is_wr) begin
                chk("awid", awid, g); chk("awaddr", awaddr, req_addr[g]);
                chk("awlen", awlen, req_len[g]); chk("awsize", awsize, {1'b0, req_size[g]});
                chk("awattr", {awburst, awlock, awcache, awprot}, 11'h200);
            end else begin
                chk("arid", arid, g); chk("araddr", araddr, req_addr[g]);
                chk("arlen", arlen, req_len[g]); chk("arsize", arsize, {1'b0, req_size[g]});
                chk("arattr", {arburst, arlock, arcache, arprot}, 11'h200);
            end
        end
        tick();
        arready = 1'b0; awready = 1'b0; m_req[g] = 1'b0; pend[g] = 1'b0;
        rr_ptr = (g + 1) % NM;
        if (!is_wr) begin
            for (b = 0; b <= len; b++) begin
                if (glitch_m >= 0 && b == 0) begin
                    m_req[glitch_m] = 1'b1; tick(); m_req[glitch_m] = 1'b0;
                end
                if (abort_at == b) begin
                    m_req = '0; pend = '0;
                    reset = 1'b1; tick(); reset = 1'b0;
                    rvalid = 1'b1; settle();
                    chk("abort_rready", rready, 0);
                    chk("abort_ret_valid", m_ret_valid, 0);
                    chk("abort_idle", {arvalid, awvalid, bready, wvalid}, 0);
                    rvalid = 1'b0; rr_ptr = 0;
                    return;
                end
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    settle(); chk("r_gap", m_ret_valid, 0); chk("rready", rready, 1); tick();
                end
                resp = (rresp_force >= 0) ? 2'(rresp_force) : (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
                rvalid = 1'b1; rdata = rd_val(req_addr[g], b); rlast = (b == len); rresp = resp;
                settle();
                chk("ret_valid", m_ret_valid, 1 << g);
                chk("ret_data", m_ret_data, rd_val(req_addr[g], b));
                chk("ret_last", m_ret_last, b == len);
                chk("r_err", m_resp_err, resp[1]);
                tick();
                rvalid = 1'b0; rlast = 1'b0;
            end
            settle();
            chk("r_done_idle", rready, 0);
        end else begin
            b = 0; cyc = 0;
            while (b <= len && cyc < 200) begin
                wv   = wtoggle ? 1'b1 : ($urandom_range(0, 3) != 0);
                wrdy = wtoggle ? (cyc % 2 == 1) : ($urandom_range(0, 3) != 0);
                m_wvalid[g] = wv; m_wdata[32*g +: 32] = wd_val(g, b);
                m_wstrb[4*g +: 4] = ws_val(b); wready = wrdy;
                settle();
                chk("wvalid", wvalid, wv);
                chk("m_wready", m_wready, wrdy ? (1 << g) : 0);
                if (wv) begin
                    chk("wdata", wdata, wd_val(g, b)); chk("wstrb", wstrb, ws_val(b));
                    chk("wlast", wlast, b == len); chk("wid", wid, g);
                end
                hs = wv && wrdy;
                tick();
                if (hs) b++;
                cyc++;
            end
            m_wvalid = '0; wready = 1'b0;
            chk("w_beats", b, len + 1);
            d = $urandom_range(0, 2);
            repeat (d) begin
                settle(); chk("bready", bready, 1); chk("wr_done_early", m_wr_done, 0);
                chk("w_after_last", wvalid, 0); tick();
            end
            resp = (bresp_force >= 0) ? 2'(bresp_force) : (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
            bvalid = 1'b1; bresp = resp;
            settle();
            chk("wr_done", m_wr_done, 1 << g);
            chk("b_err", m_resp_err, resp[1]);
            tick();
            bvalid = 1'b0;
            settle();
            chk("b_done_idle", bready, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        m_req = '0; m_wr = '0; m_size = '0; m_len = '0; m_addr = '0;
        m_wdata = '0; m_wstrb = '0; m_wvalid = '0; pend = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
        repeat (3) tick();
        settle();
        chk("rst_axi_valids", {arvalid, awvalid, rready, bready, wvalid}, 0);
        chk("rst_master_out", {m_addr_ok, m_wready, m_ret_valid, m_wr_done}, 0);
        chk("rst_err", m_resp_err, 0);
        reset = 1'b0;
        tick();

        // Both masters read at once; slow arready on the first address.
        set_req(0, 1'b0, 2'd2, 8'd3, 32'h1000_0040);
        set_req(1, 1'b0, 2'd2, 8'd0, 32'h2000_0080);
        ar_delay_force = 2;
        serve();
        ar_delay_force = -1;
        serve();

        // Master 1 four-beat write with toggling wready and an error response.
        wtoggle = 1'b1; bresp_force = 2;
        set_req(1, 1'b1, 2'd2, 8'd3, 32'h1c00_0100);
        serve();
        wtoggle = 1'b0; bresp_force = -1;

        rresp_force = 0;
        set_req(0, 1'b0, 2'd2, 8'd1, 32'h3000_0000);
        serve();
        rresp_force = -1;

        // Both masters requesting continuously across four transactions.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NM; k++)
                if (!pend[k]) set_req(k, 1'b0, 2'd2, 8'd0, 32'h4000_0000 + 32'(16 * k));
            serve();
        end
        while (pend != 0) serve();

        // A request raised and dropped mid-transaction must never be issued.
        glitch_m = 1;
        set_req(0, 1'b0, 2'd1, 8'd2, 32'h5000_0010);
        serve();
        glitch_m = -1;
        repeat (3) begin settle(); chk("no_ghost", {arvalid, awvalid}, 0); tick(); end

        // Reset in the middle of a read burst, then a normal request.
        abort_at = 2;
        set_req(0, 1'b0, 2'd2, 8'd3, 32'h6000_0000);
        serve();
        abort_at = -1;
        set_req(1, 1'b0, 2'd2, 8'd1, 32'h6100_0000);
        serve();

        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NM; k++)
                if (!pend[k] && $urandom_range(0, 1) == 1)
                    set_req(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                            8'($urandom_range(0, 15)), $urandom & 32'hFFFF_FFFC);
            if (pend == 0)
                set_req(0, 1'($urandom_range(0, 1)), 2'd2, 8'($urandom_range(0, 7)),
                        $urandom & 32'hFFFF_FFFC);
            serve();
        end
        for (int i = 0; i < NM && pend != 0; i++) serve();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
